lc3_mem_loader: RTL and testbench

Bus initiator that drives the LC-3 memory port (mar/mdr/memwe) from the bench side: it accepts a stream of program words over a valid/ready handshake, writes them into memory starting at a base address, and holds the CPU in reset until the image is loaded. It sits between the test bench and the memory, alongside the CPU. The bench keeps the CPU and the loader from driving the memory port at the same time by using the `cpu_reset` output. An optional read-back checksum pass confirms the image before the CPU is released.

---
 rtl/lc3_mem_loader.sv | 153 +++++++++++++++
 tb/tb_lc3_mem_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_loader.sv
// LC-3 program loader: streams words into memory over a valid/ready handshake and holds the CPU in reset until done.
// Define LC3_LOADER_VERIFY_EN to add a read-back checksum pass before the CPU is released.
module lc3_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [DATA_W-1:0] memOut,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              memwe,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // state  | meaning
  // IDLE   | waiting for start, CPU held in reset
  // WRITE  | accepting words, one memory write per handshake
  // DRAIN  | final write on the bus
  // VERIFY | reading the image back and summing it
  // DONE   | image loaded, CPU released
  // ERROR  | checksum mismatch, CPU stays in reset
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    DRAIN  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [15:0]       sum_q;
  logic              handshake;

`ifdef LC3_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       len_q;
  logic [16:0]       vidx_q;
  logic [15:0]       rsum_q;
`else
  logic              unused_mem;
  assign unused_mem = ^memOut;
`endif

  assign load_ready = (state_q == WRITE) && (remaining_q != 16'd0);
  assign handshake  = load_valid && load_ready;
  assign done       = (state_q == DONE);
  assign busy       = (state_q == WRITE) || (state_q == DRAIN) || (state_q == VERIFY);
  assign cpu_reset  = (state_q != DONE);
`ifdef LC3_LOADER_VERIFY_EN
  assign error      = (state_q == ERROR);
`else
  assign error      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = (length != 16'd0) ? WRITE : DONE;
      end
      WRITE: begin
        if (handshake && remaining_q == 16'd1) state_d = DRAIN;
      end
`ifdef LC3_LOADER_VERIFY_EN
      DRAIN: state_d = VERIFY;
      // Last cycle of the pass: rsum has absorbed the final read data.
      VERIFY: begin
        if (vidx_q == {1'b0, len_q} + 17'd1) state_d = (rsum_q == sum_q) ? DONE : ERROR;
      end
`else
      DRAIN: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar         <= '0;
      mdr         <= '0;
      memwe       <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
`ifdef LC3_LOADER_VERIFY_EN
      base_q      <= '0;
      len_q       <= '0;
      vidx_q      <= '0;
      rsum_q      <= '0;
`endif
    end else begin
      memwe <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= length;
            sum_q       <= '0;
`ifdef LC3_LOADER_VERIFY_EN
            base_q      <= base_addr;
            len_q       <= length;
            rsum_q      <= '0;
`endif
          end
        end
        WRITE: begin
          if (handshake) begin
            mar         <= addr_q;
            mdr         <= load_data;
            memwe       <= 1'b1;
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - 16'd1;
            sum_q       <= sum_q + 16'(load_data);
          end
        end
`ifdef LC3_LOADER_VERIFY_EN
        DRAIN: begin
          mar    <= base_q;
          vidx_q <= '0;
          rsum_q <= '0;
        end
        // memOut lags mar by one cycle, so data for read i arrives at vidx i+1.
        VERIFY: begin
          mar    <= mar + ADDR_W'(1);
          vidx_q <= vidx_q + 17'd1;
          if (vidx_q != 17'd0 && vidx_q <= {1'b0, len_q})
            rsum_q <= rsum_q + 16'(memOut);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_loader.sv
// Directed bench for lc3_mem_loader with a synchronous-read memory model and a write log.
module tb_lc3_mem_loader;
  logic        clk = 1'b0;
  logic        reset, start, load_valid, load_ready, memwe, cpu_reset, busy, done, error;
  logic [15:0] base_addr, length, load_data, memOut, mar, mdr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_hs = 0;
  int end_cyc = 0;
`ifdef LC3_LOADER_VERIFY_EN
  localparam int VERIFY_EXTRA = 1;
`else
  localparam int VERIFY_EXTRA = 0;
`endif

  lc3_mem_loader #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .memOut(memOut), .mar(mar), .mdr(mdr), .memwe(memwe),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = 16'h3001;
  always @(posedge clk) begin
    if (memwe) mem[mar] <= mdr;
    memOut <= (corrupt_en && mar == corrupt_addr) ? 16'h0000 : mem[mar];
  end

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  always @(negedge clk) begin
    if (memwe === 1'b1) begin
      wr_addr.push_back(mar);
      wr_data.push_back(mdr);
      wr_cyc.push_back(cyc);
    end
  end

  logic [15:0] words [8];

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Presents words[0..n-1]; vmask bit p gives load_valid in cycle p; start pulses in cycle start_at.
  task automatic feed(input int n, input logic [31:0] vmask, input int start_at);
    int idx = 0;
    int p = 0;
    while (idx < n && p < 100) begin
      load_valid = (p < 32) ? vmask[p] : 1'b1;
      load_data  = words[idx];
      start      = (p == start_at);
      if (start) begin
        base_addr = 16'h1234;
        length    = 16'd9;
      end
      if (load_valid && load_ready) begin
        last_hs = cyc + 1;
        idx++;
      end
      @(negedge clk);
      p++;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    vectors++;
    if (idx != n) begin
      miscompares++;
      $display("FAIL feed: accepted %0d words, required %0d", idx, n);
    end
  endtask

  task automatic wait_end();
    int g = 0;
    while (done !== 1'b1 && error !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    end_cyc = cyc;
    vectors++;
    if (g >= 100) begin
      miscompares++;
      $display("FAIL wait_end: done/error not seen within %0d cycles", g);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mar, mdr, memwe, cpu_reset, load_ready, busy, done, error} !== {32'h0, 6'b010000}) begin
      miscompares++;
      $display("FAIL reset_state: got %h, required %h",
               {mar, mdr, memwe, cpu_reset, load_ready, busy, done, error}, {32'h0, 6'b010000});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] ea [3];
    ea = '{16'h3000, 16'h3001, 16'h3002};
    words[0] = 16'h1021; words[1] = 16'h5260; words[2] = 16'h0FFE;
    clear_log();
    do_start(16'h3000, 16'd3);
    vectors++;
    if ({load_ready, busy, cpu_reset} !== 3'b111) begin
      miscompares++;
      $display("FAIL basic_write_state: got %b, required 111", {load_ready, busy, cpu_reset});
    end
    feed(3, 32'hFFFF_FFFF, -1);
    wait_end();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wr_addr.size() <= i || wr_addr[i] !== ea[i] || wr_data[i] !== words[i] ||
          wr_cyc[i] !== last_hs - 2 + i) begin
        miscompares++;
        $display("FAIL basic_write%0d: log size %0d, required addr %h data %h at cycle %0d",
                 i, wr_addr.size(), ea[i], words[i], last_hs - 2 + i);
      end
    end
    vectors++;
    if (wr_addr.size() != 3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d writes, required 3", wr_addr.size());
    end
    vectors++;
    if (end_cyc != last_hs + 1 + VERIFY_EXTRA * 5) begin
      miscompares++;
      $display("FAIL basic_done_time: got cycle %0d, required %0d", end_cyc, last_hs + 1 + VERIFY_EXTRA * 5);
    end
    vectors++;
    if ({done, cpu_reset, busy, error, memwe} !== 5'b10000) begin
      miscompares++;
      $display("FAIL basic_done_state: got %b, required 10000", {done, cpu_reset, busy, error, memwe});
    end
    vectors++;
    if ({mem[16'h3000], mem[16'h3001], mem[16'h3002]} !== 48'h1021_5260_0FFE) begin
      miscompares++;
      $display("FAIL basic_mem: got %h, required 102152600ffe", {mem[16'h3000], mem[16'h3001], mem[16'h3002]});
    end
  endtask

  task automatic test_backpressure();
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
    clear_log();
    do_start(16'h2000, 16'd3);
    feed(3, 32'b10101, -1);
    wait_end();
    vectors++;
    if (wr_addr.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: got %0d writes, required 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_addr[i] !== 16'h2000 + 16'(i) || wr_data[i] !== words[i] || wr_cyc[i] !== wr_cyc[0] + 2 * i) begin
          miscompares++;
          $display("FAIL bp_write%0d: got addr %h data %h offset %0d, required %h %h %0d",
                   i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], 16'h2000 + 16'(i), words[i], 2 * i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [3];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000};
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    clear_log();
    do_start(16'hFFFE, 16'd3);
    feed(3, 32'hFFFF_FFFF, -1);
    wait_end();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wr_addr.size() <= i || wr_addr[i] !== ea[i] || wr_data[i] !== words[i]) begin
        miscompares++;
        $display("FAIL wrap_write%0d: log size %0d, required addr %h data %h", i, wr_addr.size(), ea[i], words[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    clear_log();
    do_start(16'h4000, 16'd0);
    vectors++;
    if ({done, busy, cpu_reset, memwe, load_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL zero_len_state: got %b, required 10000", {done, busy, cpu_reset, memwe, load_ready});
    end
    @(negedge clk);
    vectors++;
    if (wr_addr.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes: got %0d writes, required 0", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    words[0] = 16'h0A0A; words[1] = 16'h0B0B;
    clear_log();
    do_start(16'h5000, 16'd5);
    feed(2, 32'hFFFF_FFFF, -1);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mar, memwe, cpu_reset, load_ready, busy, done, error} !== {16'h0, 6'b010000}) begin
      miscompares++;
      $display("FAIL midreset_state: got %h, required %h",
               {mar, memwe, cpu_reset, load_ready, busy, done, error}, {16'h0, 6'b010000});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_addr.size() != 2 || mem[16'h5001] !== 16'h0B0B) begin
      miscompares++;
      $display("FAIL midreset_partial: got %0d writes mem %h, required 2 writes mem 0b0b", wr_addr.size(), mem[16'h5001]);
    end
    words[0] = 16'h6001; words[1] = 16'h6002;
    clear_log();
    do_start(16'h6000, 16'd2);
    feed(2, 32'hFFFF_FFFF, -1);
    wait_end();
    vectors++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 16'h6000 || wr_addr[1] !== 16'h6001 ||
        wr_data[1] !== 16'h6002 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_reload: got %0d writes done %b, required 2 writes at 6000/6001 done 1",
               wr_addr.size(), done);
    end
  endtask

  task automatic test_ignored_start();
    words[0] = 16'h7A00; words[1] = 16'h7A01; words[2] = 16'h7A02;
    clear_log();
    do_start(16'h7000, 16'd3);
    feed(3, 32'hFFFF_FFFF, 1);
    wait_end();
    vectors++;
    if (wr_addr.size() != 3 || wr_addr[0] !== 16'h7000 || wr_addr[1] !== 16'h7001 ||
        wr_addr[2] !== 16'h7002 || wr_data[2] !== 16'h7A02) begin
      miscompares++;
      $display("FAIL ignored_start: got %0d writes, required 3 at 7000..7002", wr_addr.size());
    end
    vectors++;
    if (end_cyc != last_hs + 1 + VERIFY_EXTRA * 5 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_start_done: got cycle %0d done %b, required %0d done 1",
               end_cyc, done, last_hs + 1 + VERIFY_EXTRA * 5);
    end
  endtask

`ifdef LC3_LOADER_VERIFY_EN
  task automatic test_verify_error();
    words[0] = 16'h1021; words[1] = 16'h5260; words[2] = 16'h0FFE;
    corrupt_en = 1'b1;
    do_start(16'h3000, 16'd3);
    feed(3, 32'hFFFF_FFFF, -1);
    wait_end();
    vectors++;
    if ({done, error, cpu_reset, busy} !== 4'b0110 || end_cyc != last_hs + 6) begin
      miscompares++;
      $display("FAIL verify_error: got %b at cycle %0d, required 0110 at %0d",
               {done, error, cpu_reset, busy}, end_cyc, last_hs + 6);
    end
    corrupt_en = 1'b0;
  endtask
`endif

  initial begin
    start = 1'b0; load_valid = 1'b0; load_data = '0; base_addr = '0; length = '0; reset = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_reset_mid_load();
    test_ignored_start();
`ifdef LC3_LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
